// File: rtl/adiabatic_adder_pkg.sv
// Shared types and constants for the adiabatic adder core.
// The P/G export feature is selected with ADIABATIC_ADDER_PG_EXPORT_EN.
package adiabatic_adder_pkg;

  localparam int ADDER_WIDTH = 16;
  localparam int NUM_PHASES  = 8;
  localparam int PHASE_W     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [PHASE_W-1:0] PH_HOLD = 3'd0;
  localparam logic [PHASE_W-1:0] PH_PG   = 3'd1;
  localparam logic [PHASE_W-1:0] PH_PFX0 = 3'd2;
  localparam logic [PHASE_W-1:0] PH_PFX1 = 3'd3;
  localparam logic [PHASE_W-1:0] PH_PFX2 = 3'd4;
  localparam logic [PHASE_W-1:0] PH_PFX3 = 3'd5;
  localparam logic [PHASE_W-1:0] PH_SUM  = 3'd6;
  localparam logic [PHASE_W-1:0] PH_OUT  = 3'd7;

  typedef struct packed {
    logic [ADDER_WIDTH-1:0] g;
    logic [ADDER_WIDTH-1:0] p;
  } gp_t;

  // One Kogge-Stone level; low bits already span to bit 0, so zero fill is harmless.
  function automatic gp_t ks_level(input gp_t x, input int unsigned span);
    gp_t y;
    y.g = x.g | (x.p & (x.g << span));
    y.p = x.p & (x.p << span);
    return y;
  endfunction

endpackage

// File: rtl/adiabatic_phase_gen.sv
// Phase counter for the evaluation sequence plus the emulated
// adiabatic power-clock phase outputs.
module adiabatic_phase_gen
  import adiabatic_adder_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  run_i,
  output logic [PHASE_W-1:0]    phase_o,
  output logic [NUM_PHASES-1:0] clkp_o,
  output logic [NUM_PHASES-1:0] clkn_o
);

  logic [PHASE_W-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (clear_i)    phase_d = '0;
    else if (run_i) phase_d = phase_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end

  always_comb begin
    clkp_o = '0;
    clkn_o = '0;
    if (run_i) begin
      clkp_o[phase_q] = 1'b1;
      clkn_o          = ~clkp_o;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/adiabatic_adder_core.sv
// Multi-phase Kogge-Stone adder emulating an adiabatic power-clock pipeline.
// Define ADIABATIC_ADDER_PG_EXPORT_EN to export the latched-operand P/G vectors.
module adiabatic_adder_core
  import adiabatic_adder_pkg::*;
#(
  parameter int WIDTH      = ADDER_WIDTH,
  parameter int DONE_PULSE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic                  cin,
  output logic                  busy,
  output logic [WIDTH-1:0]      out,
  output logic                  cout,
  output logic                  calculation_done,
  output logic [NUM_PHASES-1:0] clkp_out,
  output logic [NUM_PHASES-1:0] clkn_out,
  output logic [WIDTH-1:0]      propagate,
  output logic [WIDTH-1:0]      generate_
);

  state_t             state_q, state_d;
  logic               done_q, done_d;
  logic               accept;
  logic               running;
  logic [PHASE_W-1:0] phase;
  logic [WIDTH-1:0]   a_q, b_q, p_q, out_q;
  logic               cin_q, cout_q;
  gp_t                pfx_q;
  logic [WIDTH:0]     sum_q;

  assign accept  = start && ((state_q == IDLE) || (state_q == DONE));
  assign running = (state_q == EVAL);

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    case (state_q)
      IDLE: if (start) state_d = EVAL;
      EVAL: if (phase == PH_OUT) begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        if (start) begin
          state_d = EVAL;
          done_d  = 1'b0;
        end else if (DONE_PULSE != 0) begin
          done_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  adiabatic_phase_gen u_phase_gen (
    .clk     (clk),
    .reset   (reset),
    .clear_i (accept),
    .run_i   (running),
    .phase_o (phase),
    .clkp_o  (clkp_out),
    .clkn_o  (clkn_out)
  );

`ifdef ADIABATIC_ADDER_PG_EXPORT_EN
  logic [WIDTH-1:0] g_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      p_q     <= '0;
      pfx_q   <= '0;
      sum_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
`ifdef ADIABATIC_ADDER_PG_EXPORT_EN
      g_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        cin_q <= cin;
      end
      if (running) begin
        case (phase)
          PH_HOLD: ;
          PH_PG: begin
            p_q     <= a_q ^ b_q;
            // Carry-in folds into bit 0's generate so the prefix sees it as a normal group.
            pfx_q.g <= (a_q & b_q) | {{(WIDTH-1){1'b0}}, (a_q[0] ^ b_q[0]) & cin_q};
            pfx_q.p <= a_q ^ b_q;
`ifdef ADIABATIC_ADDER_PG_EXPORT_EN
            g_q     <= a_q & b_q;
`endif
          end
          PH_PFX0, PH_PFX1, PH_PFX2, PH_PFX3:
            pfx_q <= ks_level(pfx_q, 1 << (phase - PH_PFX0));
          PH_SUM:
            sum_q <= {pfx_q.g[WIDTH-1], p_q ^ {pfx_q.g[WIDTH-2:0], cin_q}};
          PH_OUT: begin
            out_q  <= sum_q[WIDTH-1:0];
            cout_q <= sum_q[WIDTH];
          end
          default: ;
        endcase
      end
    end
  end

  assign busy             = running;
  assign out              = out_q;
  assign cout             = cout_q;
  assign calculation_done = done_q;

`ifdef ADIABATIC_ADDER_PG_EXPORT_EN
  assign propagate = p_q;
  assign generate_ = g_q;
`else
  assign propagate = '0;
  assign generate_ = '0;
`endif

endmodule

// File: tb/tb_adiabatic_adder_core.sv
// Directed bench for adiabatic_adder_core; follows ADIABATIC_ADDER_PG_EXPORT_EN for P/G expectations.
module tb_adiabatic_adder_core;

`ifdef ADIABATIC_ADDER_PG_EXPORT_EN
  localparam bit PG_ON = 1'b1;
`else
  localparam bit PG_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, cin = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, cout, done;
  logic [15:0] out, prop, gen;
  logic [7:0]  clkp, clkn;

  logic        start1 = 1'b0, cin1 = 1'b0;
  logic [15:0] a1 = '0, b1 = '0;
  logic        busy1, cout1, done1;
  logic [15:0] out1, prop1, gen1;
  logic [7:0]  clkp1, clkn1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adiabatic_adder_core #(.WIDTH(16), .DONE_PULSE(1)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .out(out), .cout(cout), .calculation_done(done),
    .clkp_out(clkp), .clkn_out(clkn), .propagate(prop), .generate_(gen)
  );

  adiabatic_adder_core #(.WIDTH(16), .DONE_PULSE(0)) dut_hold (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .out(out1), .cout(cout1), .calculation_done(done1),
    .clkp_out(clkp1), .clkn_out(clkn1), .propagate(prop1), .generate_(gen1)
  );

  // Returns at the falling edge just after the accept edge (phase 0).
  task automatic start_op(input logic [15:0] aa, input logic [15:0] bb, input logic cc);
    @(negedge clk);
    a = aa; b = bb; cin = cc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, out, cout, done, clkp, clkn, prop, gen} !== '0) begin
      errors++;
      $display("FAIL reset_dut got busy=%b out=%h cout=%b done=%b clkp=%h clkn=%h p=%h g=%h want all 0",
               busy, out, cout, done, clkp, clkn, prop, gen);
    end
    checks++;
    if ({busy1, out1, cout1, done1, clkp1, clkn1, prop1, gen1} !== '0) begin
      errors++;
      $display("FAIL reset_hold got busy=%b out=%h done=%b clkp=%h want all 0", busy1, out1, done1, clkp1);
    end
    reset = 1'b0;
  endtask

  task automatic test_carry_wrap();
    start_op(16'hFFFF, 16'h0001, 1'b0);
    repeat (7) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wrap_phase7 got done=%b busy=%b want done=0 busy=1", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out !== 16'h0000 || cout !== 1'b1) begin
      errors++;
      $display("FAIL wrap_result got done=%b busy=%b out=%h cout=%b want 1 0 0000 1", done, busy, out, cout);
    end
    checks++;
    if (prop !== (PG_ON ? 16'hFFFE : 16'h0000) || gen !== (PG_ON ? 16'h0001 : 16'h0000)) begin
      errors++;
      $display("FAIL wrap_pg got p=%h g=%h want p=%h g=%h", prop, gen,
               PG_ON ? 16'hFFFE : 16'h0000, PG_ON ? 16'h0001 : 16'h0000);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || out !== 16'h0000 || cout !== 1'b1) begin
      errors++;
      $display("FAIL wrap_pulse got done=%b out=%h cout=%b want 0 0000 1", done, out, cout);
    end
  endtask

  task automatic test_phases();
    logic [7:0] one;
    logic [7:0] exp_p;
    one = 8'h01;
    checks++;
    if (clkp !== 8'h00 || clkn !== 8'h00) begin
      errors++;
      $display("FAIL phase_done_idle got clkp=%h clkn=%h want 00 00", clkp, clkn);
    end
    start_op(16'h1234, 16'h4321, 1'b1);
    for (int k = 0; k < 8; k++) begin
      exp_p = one << k;
      checks++;
      if (clkp !== exp_p || clkn !== ~exp_p || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL phase_step%0d got clkp=%h clkn=%h busy=%b done=%b want clkp=%h clkn=%h",
                 k, clkp, clkn, busy, done, exp_p, ~exp_p);
      end
      if (!PG_ON) begin
        checks++;
        if (prop !== 16'h0000 || gen !== 16'h0000) begin
          errors++;
          $display("FAIL phase_pg_off got p=%h g=%h want 0000 0000", prop, gen);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || out !== 16'h5556 || cout !== 1'b0 || clkp !== 8'h00 || clkn !== 8'h00) begin
      errors++;
      $display("FAIL phase_result got done=%b out=%h cout=%b clkp=%h clkn=%h want 1 5556 0 00 00",
               done, out, cout, clkp, clkn);
    end
    checks++;
    if (prop !== (PG_ON ? 16'h5115 : 16'h0000) || gen !== (PG_ON ? 16'h0220 : 16'h0000)) begin
      errors++;
      $display("FAIL phase_pg got p=%h g=%h", prop, gen);
    end
  endtask

  task automatic test_back_to_back();
    start_op(16'h1111, 16'h2222, 1'b0);
    repeat (3) @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; start = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (done !== 1'b1 || out !== 16'h3333 || cout !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start got done=%b out=%h cout=%b want 1 3333 0", done, out, cout);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || clkp !== 8'h01 || out !== 16'h3333) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b done=%b clkp=%h out=%h want 1 0 01 3333", busy, done, clkp, out);
    end
    repeat (7) @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_early got done=%b want 0", done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || out !== 16'hFFFF || cout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_result got done=%b out=%h cout=%b want 1 ffff 0", done, out, cout);
    end
  endtask

  task automatic test_reset_mid();
    start_op(16'h0F0F, 16'h00F1, 1'b1);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, out, cout, done, clkp, clkn, prop, gen} !== '0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b out=%h cout=%b done=%b clkp=%h clkn=%h want all 0",
               busy, out, cout, done, clkp, clkn);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || out !== 16'h0000) begin
        errors++;
        $display("FAIL reset_discard cycle %0d got done=%b busy=%b out=%h want 0 0 0000", k, done, busy, out);
      end
    end
    start_op(16'h0001, 16'h0001, 1'b0);
    repeat (8) @(negedge clk);
    checks++;
    if (done !== 1'b1 || out !== 16'h0002 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_fresh got done=%b out=%h cout=%b want 1 0002 0", done, out, cout);
    end
  endtask

  task automatic test_hold_mode();
    @(negedge clk);
    a1 = 16'h7FFF; b1 = 16'h0001; cin1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (done1 !== 1'b0) begin
      errors++;
      $display("FAIL hold_early got done=%b want 0", done1);
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b1 || out1 !== 16'h8000 || cout1 !== 1'b0) begin
      errors++;
      $display("FAIL hold_result got done=%b out=%h cout=%b want 1 8000 0", done1, out1, cout1);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (done1 !== 1'b1 || busy1 !== 1'b0) begin
        errors++;
        $display("FAIL hold_level cycle %0d got done=%b busy=%b want 1 0", k, done1, busy1);
      end
    end
    a1 = 16'hFFFF; b1 = 16'hFFFF; cin1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL hold_clear got done=%b busy=%b want 0 1", done1, busy1);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (done1 !== 1'b1 || out1 !== 16'hFFFF || cout1 !== 1'b1) begin
      errors++;
      $display("FAIL hold_second got done=%b out=%h cout=%b want 1 ffff 1", done1, out1, cout1);
    end
    checks++;
    if (!PG_ON && (prop1 !== 16'h0000 || gen1 !== 16'h0000)) begin
      errors++;
      $display("FAIL hold_pg_off got p=%h g=%h want 0000 0000", prop1, gen1);
    end
  endtask

  initial begin
    test_reset();
    test_carry_wrap();
    test_phases();
    test_back_to_back();
    test_reset_mid();
    test_hold_mode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adiabatic_adder_core.md
ADIABATIC_ADDER_CORE -- requirements
Module: adiabatic_adder_core

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width; only 16 is supported.
REQ-002 SHALL have parameter DONE_PULSE, default 1; 1 = calculation_done is a one-cycle pulse, 0 = calculation_done is held until the next accepted start.
REQ-003 SHALL have one clock; reset is asynchronous and active-high; ports clk (input, 1, rising-edge clock) and reset (input, 1, async active-high reset).
REQ-004 SHALL have start (input, 1): request a new addition.
REQ-005 SHALL have a, b (input, 16 each): operands; cin (input, 1): carry-in.
REQ-006 SHALL have busy (output, 1): operation in progress.
REQ-007 SHALL have out (output, 16): sum; cout (output, 1): carry-out.
REQ-008 SHALL have calculation_done (output, 1): result valid.
REQ-009 SHALL have clkp_out and clkn_out (output, 8 each): emulated adiabatic power-clock phases.
REQ-010 SHALL have propagate and generate_ (output, 16 each): bitwise P/G of the latched operands.

Function
REQ-011 SHALL implement FSM states IDLE, EVAL, DONE.
REQ-012 SHALL accept start only in IDLE or DONE; the accept cycle latches a, b, cin, enters EVAL, sets busy=1 and clears phase counter to 0.
REQ-013 SHALL ignore start while in EVAL; latched operands stay unchanged.
REQ-014 SHALL advance a 3-bit phase counter once per cycle in EVAL, with stages: 0 operand hold, 1 P/G, 2-5 Kogge-Stone prefix levels (span 1, 2, 4, 8), 6 sum, 7 output register.
REQ-015 SHALL drive clkp_out one-hot with bit k high during phase k in EVAL, and 0x00 otherwise.
REQ-016 SHALL drive clkn_out to ~clkp_out in EVAL, and 0x00 otherwise.
REQ-017 SHALL, after phase 7, go to DONE, drop busy, and assert calculation_done exactly 8 cycles after the accept edge.
REQ-018 SHALL give out = (a+b+cin)[15:0] and cout = bit 16 of that sum; both are updated only on the DONE entry and held until the next DONE entry.
REQ-019 SHALL, when DONE_PULSE=1, deassert calculation_done after one cycle while remaining in DONE.
REQ-020 SHALL, when DONE_PULSE=0, hold calculation_done until the next accepted start.
REQ-021 SHALL, when start is asserted in the DONE cycle, accept it: calculation_done deasserts the next cycle and busy reasserts, with no idle gap.
REQ-022 SHALL give propagate = a^b and generate_ = a&b of the latched operands, registered at phase 1 and held until the next phase 1.
REQ-023 SHALL produce a 17-bit arithmetic result with no overflow flag; wrap-around appears only through cout.

Reset
REQ-024 SHALL, while reset=1, immediately force: state IDLE; phase counter 0; busy, calculation_done, cout 0; out, propagate, generate_ 0x0000; clkp_out, clkn_out 0x00.
REQ-025 SHALL abort any in-flight operation on reset and discard its result.
REQ-026 SHALL, after reset release, accept start on the first clk edge.

Configuration
REQ-027 SHALL, with macro ADIABATIC_ADDER_PG_EXPORT_EN defined, drive propagate/generate_ per REQ-022.
REQ-028 SHALL, without ADIABATIC_ADDER_PG_EXPORT_EN, tie propagate/generate_ to 0 and remove their registers; sum, cout and timing are unchanged.

Structure
REQ-029 SHALL put in package adiabatic_adder_pkg: state enum (IDLE, EVAL, DONE), ADDER_WIDTH=16, NUM_PHASES=8, and the phase index constants for the P/G, prefix, sum and output stages.
REQ-030 SHALL implement the phase counter plus clkp_out/clkn_out decode in sub-module adiabatic_phase_gen; the prefix network stays in the top module.

Verification
REQ-031 SHALL check: a=0xFFFF, b=0x0001, cin=0, start -> 8 cycles later out=0x0000, cout=1, calculation_done=1 for one cycle; propagate=0xFFFE, generate_=0x0001.
REQ-032 SHALL check: a=0x1234, b=0x4321, cin=1 -> out=0x5556, cout=0; clkp_out steps 0x01,0x02,...,0x80 with clkn_out its complement; both are 0x00 in IDLE/DONE.
REQ-033 SHALL check: start held high at phase 3 with a=0xAAAA -> operands unchanged and the result matches the first operands; back-to-back start in DONE -> the next result arrives 8 cycles later.
REQ-034 SHALL check: reset asserted at phase 4 mid-clock-low -> all outputs 0 immediately, no calculation_done, and a fresh start after release completes normally.
REQ-035 SHALL check: with DONE_PULSE=0, calculation_done stays high for 5 idle cycles until the next start; with the macro undefined, propagate and generate_ stay 0x0000 throughout.
